alu_core: RTL and testbench

//  Multi-cycle 16-bit ALU; responder side of the control unit's bgn/rdy execute handshake.

---
 rtl/cpu_isa_pkg.sv | 56 +++++
 rtl/alu_core_if.sv | 29 ++
 rtl/alu_muldiv_iter.sv | 103 ++++++++++
 rtl/alu_core.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_core.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: ISA op codes shared with the control unit, ALU FSM state encoding,
// flag bundle and default datapath sizes.
package cpu_isa_pkg;

   localparam int ALU_WIDTH    = 16;
   localparam int ALU_ITER_CNT = ALU_WIDTH;

   typedef enum logic [4:0] {
      OP_NOP = 5'd0,
      OP_HLT = 5'd1,
      OP_MOV = 5'd2,
      OP_STR = 5'd3,
      OP_LDR = 5'd4,
      OP_ADD = 5'd5,
      OP_SUB = 5'd6,
      OP_INC = 5'd7,
      OP_DEC = 5'd8,
      OP_CMP = 5'd9,
      OP_TST = 5'd10,
      OP_AND = 5'd11,
      OP_OR  = 5'd12,
      OP_XOR = 5'd13,
      OP_NOT = 5'd14,
      OP_LSL = 5'd15,
      OP_LSR = 5'd16,
      OP_RSL = 5'd17,
      OP_RSR = 5'd18,
      OP_MUL = 5'd19,
      OP_DIV = 5'd20,
      OP_MOD = 5'd21,
      OP_JMP = 5'd22,
      OP_BEQ = 5'd23,
      OP_BNE = 5'd24,
      OP_PSH = 5'd25,
      OP_POP = 5'd26,
      OP_SER = 5'd27
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   function automatic logic is_divide(input op_e op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_core_if.sv
// alu_core_if: bgn/rdy execute handshake between the control unit (master)
// and the ALU (slave), carrying operands, results and flags.
interface alu_core_if
   import cpu_isa_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);
   logic             bgn;
   logic [5:0]       opcode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc1;
   logic [WIDTH-1:0] acc2;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             rdy;

   modport master (
      output bgn, opcode, a, b,
      input  acc1, acc2, zero, negative, carry, overflow, rdy
   );

   modport slave (
      input  bgn, opcode, a, b,
      output acc1, acc2, zero, negative, carry, overflow, rdy
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider.
// The first iteration happens on the start edge, so o_done is high one cycle after ITER_CNT-1 further edges.
module alu_muldiv_iter
   import cpu_isa_pkg::*;
#(
   parameter int WIDTH    = ALU_WIDTH,
   parameter int ITER_CNT = ALU_ITER_CNT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int               CNT_W    = $clog2(ITER_CNT) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_CNT - 1);

   logic             r_busy;
   logic             r_done;
   logic             r_div;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_op;

   logic             w_div;
   logic [WIDTH-1:0] w_op;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_lo;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_shift;
   logic             w_fits;
   logic [WIDTH-1:0] w_next_hi;
   logic [WIDTH-1:0] w_next_lo;

   // MUL: hi = partial product, lo = multiplier. DIV: hi = remainder, lo = dividend/quotient.
   always_comb begin
      w_div = r_div;
      w_op  = r_op;
      w_hi  = r_hi;
      w_lo  = r_lo;
      if (i_start) begin
         w_div = i_div;
         w_op  = i_div ? i_b : i_a;
         w_hi  = '0;
         w_lo  = i_div ? i_a : i_b;
      end

      w_mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_op} : '0);
      w_shift   = {w_hi, w_lo[WIDTH-1]};
      w_fits    = (w_shift >= {1'b0, w_op});

      if (w_div) begin
         w_next_hi = w_fits ? (w_shift[WIDTH-1:0] - w_op) : w_shift[WIDTH-1:0];
         w_next_lo = {w_lo[WIDTH-2:0], w_fits};
      end else begin
         w_next_hi = w_mul_sum[WIDTH:1];
         w_next_lo = {w_mul_sum[0], w_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_div  <= 1'b0;
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_op   <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_start || r_busy) begin
            r_hi <= w_next_hi;
            r_lo <= w_next_lo;
         end
         if (i_start) begin
            r_div  <= i_div;
            r_op   <= w_op;
            r_cnt  <= CNT_W'(1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: rtl/alu_core.sv
// alu_core: multi-cycle ALU answering the control unit's bgn/rdy handshake.
// Define ALU_FAST_MUL_EN for a single-cycle combinational MUL; otherwise MUL shares the iterator with DIV/MOD.
module alu_core
   import cpu_isa_pkg::*;
#(
   parameter int WIDTH    = ALU_WIDTH,
   parameter int ITER_CNT = ALU_ITER_CNT
) (
   input  logic      clk,
   input  logic      rst,
   alu_core_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   alu_state_e       r_state;
   op_e              r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_iter;
   logic [WIDTH-1:0] r_acc1;
   logic [WIDTH-1:0] r_acc2;
   alu_flags_t       r_flags;
   logic             r_rdy;

   op_e                w_op_in;
   logic               w_iter_mul;
   logic               w_iter_div;
   logic               w_iter_start;
   logic               w_iter_done;
   logic               w_unused_busy;
   logic               w_unused_imm;
   logic [WIDTH-1:0]   w_iter_hi;
   logic [WIDTH-1:0]   w_iter_lo;
   logic [WIDTH-1:0]   w_mul_lo;
   logic [WIDTH-1:0]   w_mul_hi;
   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH-1:0]   w_subtr;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_sub;
   logic [SHW-1:0]     w_shamt;
   logic [2*WIDTH-1:0] w_shl;
   logic [2*WIDTH-1:0] w_shr;
   logic [WIDTH-1:0]   w_res;
   logic [WIDTH-1:0]   w_res2;
   logic               w_c;
   logic               w_v;
   logic               w_wr_acc;
   logic               w_wr_flags;
   alu_flags_t         w_flags;

   assign w_op_in      = op_e'(bus.opcode[5:1]);
   assign w_unused_imm = bus.opcode[0];

`ifdef ALU_FAST_MUL_EN
   logic [2*WIDTH-1:0] w_prod;
   assign w_prod     = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
   assign w_mul_lo   = w_prod[WIDTH-1:0];
   assign w_mul_hi   = w_prod[2*WIDTH-1:WIDTH];
   assign w_iter_mul = 1'b0;
`else
   assign w_mul_lo   = w_iter_lo;
   assign w_mul_hi   = w_iter_hi;
   assign w_iter_mul = (w_op_in == OP_MUL);
`endif

   // Divide by zero never enters the iterator; it resolves in one cycle.
   assign w_iter_div   = is_divide(w_op_in) && (bus.b != '0);
   assign w_iter_start = (r_state == ST_IDLE) && bus.bgn && (w_iter_mul || w_iter_div);

   alu_muldiv_iter #(
      .WIDTH    (WIDTH),
      .ITER_CNT (ITER_CNT)
   ) u_iter (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_iter_start),
      .i_div   (is_divide(w_op_in)),
      .i_a     (bus.a),
      .i_b     (bus.b),
      .o_busy  (w_unused_busy),
      .o_done  (w_iter_done),
      .o_hi    (w_iter_hi),
      .o_lo    (w_iter_lo)
   );

   assign w_addend = (r_op == OP_INC) ? {{(WIDTH-1){1'b0}}, 1'b1} : r_b;
   assign w_subtr  = (r_op == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : r_b;
   assign w_add    = {1'b0, r_a} + {1'b0, w_addend};
   assign w_sub    = {1'b0, r_a} - {1'b0, w_subtr};
   assign w_shamt  = r_b[SHW-1:0];
   // Double-width shifts: the half that falls off holds the bits shifted out, for C and for rotates.
   assign w_shl    = {{WIDTH{1'b0}}, r_a} << w_shamt;
   assign w_shr    = {r_a, {WIDTH{1'b0}}} >> w_shamt;

   always_comb begin
      w_res      = r_acc1;
      w_res2     = '0;
      w_c        = 1'b0;
      w_v        = 1'b0;
      w_wr_acc   = 1'b1;
      w_wr_flags = 1'b1;
      case (r_op)
         OP_ADD, OP_INC: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (r_a[MSB] == w_addend[MSB]) && (w_add[MSB] != r_a[MSB]);
         end
         OP_SUB, OP_DEC, OP_CMP: begin
            w_res    = w_sub[WIDTH-1:0];
            w_c      = w_sub[WIDTH];
            w_v      = (r_a[MSB] != w_subtr[MSB]) && (w_sub[MSB] != r_a[MSB]);
            w_wr_acc = (r_op != OP_CMP);
         end
         OP_TST: begin
            w_res    = r_a & r_b;
            w_wr_acc = 1'b0;
         end
         OP_AND: w_res = r_a & r_b;
         OP_OR:  w_res = r_a | r_b;
         OP_XOR: w_res = r_a ^ r_b;
         OP_NOT: w_res = ~r_a;
         OP_LSL: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         OP_RSL: begin
            w_res = w_shl[WIDTH-1:0] | w_shl[2*WIDTH-1:WIDTH];
            w_c   = w_shl[WIDTH];
         end
         OP_LSR: begin
            w_res = w_shr[2*WIDTH-1:WIDTH];
            w_c   = w_shr[WIDTH-1];
         end
         OP_RSR: begin
            w_res = w_shr[2*WIDTH-1:WIDTH] | w_shr[WIDTH-1:0];
            w_c   = w_shr[WIDTH-1];
         end
         OP_MUL: begin
            w_res  = w_mul_lo;
            w_res2 = w_mul_hi;
            w_v    = |w_mul_hi;
         end
         OP_DIV, OP_MOD: begin
            if (r_b == '0) begin
               w_res  = '1;
               w_res2 = r_a;
               w_v    = 1'b1;
            end else if (r_op == OP_DIV) begin
               w_res  = w_iter_lo;
               w_res2 = w_iter_hi;
            end else begin
               w_res  = w_iter_hi;
               w_res2 = w_iter_lo;
            end
         end
         default: begin
            w_wr_acc   = 1'b0;
            w_wr_flags = 1'b0;
         end
      endcase
   end

   assign w_flags = '{z: (w_res == '0), n: w_res[MSB], c: w_c, v: w_v};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_NOP;
         r_a     <= '0;
         r_b     <= '0;
         r_iter  <= 1'b0;
         r_acc1  <= '0;
         r_acc2  <= '0;
         r_flags <= '0;
         r_rdy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.bgn) begin
                  r_op    <= w_op_in;
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_iter  <= w_iter_mul || w_iter_div;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (!r_iter || w_iter_done) begin
                  if (w_wr_acc) begin
                     r_acc1 <= w_res;
                     r_acc2 <= w_res2;
                  end
                  if (w_wr_flags) begin
                     r_flags <= w_flags;
                  end
                  r_rdy   <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!bus.bgn) begin
                  r_rdy   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_rdy   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.acc1     = r_acc1;
   assign bus.acc2     = r_acc2;
   assign bus.zero     = r_flags.z;
   assign bus.negative = r_flags.n;
   assign bus.carry    = r_flags.c;
   assign bus.overflow = r_flags.v;
   assign bus.rdy      = r_rdy;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors with hand-computed results for alu_core,
// including handshake hold/drop and reset in the middle of a MUL.
module tb_alu_core;
   import cpu_isa_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

`ifdef ALU_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 17;
`endif

   alu_core_if #(.WIDTH(16)) bus ();

   alu_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // flags packed as {Z, N, C, V}
   task automatic check_out(input string tag, input logic [15:0] acc1,
                            input logic [15:0] acc2, input logic [3:0] flags);
      check({tag, "_acc1"}, {16'h0, bus.acc1}, {16'h0, acc1});
      check({tag, "_acc2"}, {16'h0, bus.acc2}, {16'h0, acc2});
      check({tag, "_flags"}, {28'h0, bus.zero, bus.negative, bus.carry, bus.overflow},
            {28'h0, flags});
   endtask

   task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int hold, input int exp_lat);
      int lat;
      bit seen;
      @(negedge clk);
      bus.opcode = {op, 1'b1};
      bus.a      = a;
      bus.b      = b;
      bus.bgn    = 1'b1;
      lat        = 0;
      seen       = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.opcode = 6'h3F;
            bus.a      = ~a;
            bus.b      = a ^ b ^ 16'h5A5A;
         end
         seen = bus.rdy;
      end
      check({tag, "_lat"}, lat, exp_lat);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_rdy"}, {31'h0, bus.rdy}, 32'h1);
      end
      bus.bgn = 1'b0;
      @(negedge clk);
      check({tag, "_rdy_drop"}, {31'h0, bus.rdy}, 32'h0);
      $display("txn %-10s op=%0d a=%h b=%h lat=%0d -> acc1=%h acc2=%h ZNCV=%b%b%b%b",
               tag, op, a, b, lat, bus.acc1, bus.acc2,
               bus.zero, bus.negative, bus.carry, bus.overflow);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit seen;
      rst        = 1'b1;
      bus.bgn    = 1'b0;
      bus.opcode = '0;
      bus.a      = '0;
      bus.b      = '0;
      repeat (3) @(negedge clk);
      check_out("reset", 16'h0, 16'h0, 4'b0000);
      check("reset_rdy", {31'h0, bus.rdy}, 32'h0);
      rst = 1'b0;

      run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 0, 2);
      check_out("add_ovf", 16'h8000, 16'h0000, 4'b0101);
      run_op("cmp_lt", OP_CMP, 16'h0003, 16'h0004, 0, 2);
      check_out("cmp_lt", 16'h8000, 16'h0000, 4'b0110);
      run_op("sub_zero", OP_SUB, 16'h0005, 16'h0005, 0, 2);
      check_out("sub_zero", 16'h0000, 16'h0000, 4'b1000);
      run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 0, 2);
      check_out("sub_ovf", 16'h7FFF, 16'h0000, 4'b0001);
      run_op("mul", OP_MUL, 16'h1234, 16'h0100, 0, MUL_LAT);
      check_out("mul", 16'h3400, 16'h0012, 4'b0001);
      run_op("tst", OP_TST, 16'h00F0, 16'h0F00, 0, 2);
      check_out("tst", 16'h3400, 16'h0012, 4'b1000);
      run_op("nop", OP_NOP, 16'hAAAA, 16'h5555, 0, 2);
      check_out("nop", 16'h3400, 16'h0012, 4'b1000);
      run_op("div", OP_DIV, 16'd100, 16'd7, 0, 17);
      check_out("div", 16'd14, 16'd2, 4'b0000);
      run_op("mod", OP_MOD, 16'd100, 16'd7, 0, 17);
      check_out("mod", 16'd2, 16'd14, 4'b0000);
      run_op("div_zero", OP_DIV, 16'd9, 16'd0, 0, 2);
      check_out("div_zero", 16'hFFFF, 16'h0009, 4'b0101);
      run_op("rsl", OP_RSL, 16'h8001, 16'h0001, 0, 2);
      check_out("rsl", 16'h0003, 16'h0000, 4'b0010);
      run_op("lsr", OP_LSR, 16'h0001, 16'h0001, 0, 2);
      check_out("lsr", 16'h0000, 16'h0000, 4'b1010);
      run_op("lsl", OP_LSL, 16'h4001, 16'h0002, 0, 2);
      check_out("lsl", 16'h0004, 16'h0000, 4'b0010);
      run_op("rsr_amt0", OP_RSR, 16'h1234, 16'h0010, 0, 2);
      check_out("rsr_amt0", 16'h1234, 16'h0000, 4'b0000);
      run_op("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF, 0, MUL_LAT);
      check_out("mul_max", 16'h0001, 16'hFFFE, 4'b0001);
      run_op("div_big", OP_DIV, 16'hFFFF, 16'h0010, 0, 17);
      check_out("div_big", 16'h0FFF, 16'h000F, 4'b0000);
      run_op("xor", OP_XOR, 16'h00FF, 16'h0F0F, 0, 2);
      check_out("xor", 16'h0FF0, 16'h0000, 4'b0000);
      run_op("not", OP_NOT, 16'h00FF, 16'h0000, 0, 2);
      check_out("not", 16'hFF00, 16'h0000, 4'b0100);
      run_op("inc_wrap", OP_INC, 16'hFFFF, 16'h0001, 0, 2);
      check_out("inc_wrap", 16'h0000, 16'h0000, 4'b1010);
      run_op("dec_ovf", OP_DEC, 16'h8000, 16'h0001, 0, 2);
      check_out("dec_ovf", 16'h7FFF, 16'h0000, 4'b0001);

      run_op("hold", OP_ADD, 16'h0001, 16'h0002, 5, 2);
      check_out("hold", 16'h0003, 16'h0000, 4'b0000);

      // bgn withdrawn while a DIV is still iterating
      @(negedge clk);
      bus.opcode = {OP_DIV, 1'b0};
      bus.a      = 16'd100;
      bus.b      = 16'd7;
      bus.bgn    = 1'b1;
      lat        = 0;
      repeat (3) begin
         @(negedge clk);
         lat++;
      end
      bus.bgn = 1'b0;
      seen    = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         seen = bus.rdy;
      end
      check("drop_exec_lat", lat, 17);
      @(negedge clk);
      check("drop_exec_rdy_off", {31'h0, bus.rdy}, 32'h0);
      check_out("drop_exec", 16'd14, 16'd2, 4'b0000);
      $display("txn %-10s lat=%0d acc1=%h acc2=%h", "drop_exec", lat, bus.acc1, bus.acc2);

      // reset lands at cycle 8 of a MUL
      @(negedge clk);
      bus.opcode = {OP_MUL, 1'b0};
      bus.a      = 16'h1234;
      bus.b      = 16'h0100;
      bus.bgn    = 1'b1;
      repeat (8) @(negedge clk);
      rst     = 1'b1;
      bus.bgn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_out("rst_mid_mul", 16'h0000, 16'h0000, 4'b0000);
      check("rst_mid_mul_rdy", {31'h0, bus.rdy}, 32'h0);
      $display("txn %-10s acc1=%h acc2=%h rdy=%b", "rst_mul", bus.acc1, bus.acc2, bus.rdy);
      run_op("add_after", OP_ADD, 16'h0002, 16'h0003, 0, 2);
      check_out("add_after", 16'h0005, 16'h0000, 4'b0000);
      run_op("div_after", OP_DIV, 16'd100, 16'd7, 0, 17);
      check_out("div_after", 16'd14, 16'd2, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
